// File: rtl/xcel_req_arbiter_if.sv
// Handshake bundle for the two-requester xcel arbiter: both requester ports
// plus the shared accelerator port, all val/rdy with xcel_req_t/xcel_resp_t payloads.
interface xcel_req_arbiter_if;
    logic        req0_val;
    logic        req0_rdy;
    logic [37:0] req0_msg;
    logic        req1_val;
    logic        req1_rdy;
    logic [37:0] req1_msg;

    logic        resp0_val;
    logic        resp0_rdy;
    logic [32:0] resp0_msg;
    logic        resp1_val;
    logic        resp1_rdy;
    logic [32:0] resp1_msg;

    logic        xcel_req_val;
    logic        xcel_req_rdy;
    logic [37:0] xcel_req_msg;
    logic        xcel_resp_val;
    logic        xcel_resp_rdy;
    logic [32:0] xcel_resp_msg;

    // Arbiter view
    modport slave (
        input  req0_val, req0_msg, req1_val, req1_msg,
        output req0_rdy, req1_rdy,
        output resp0_val, resp0_msg, resp1_val, resp1_msg,
        input  resp0_rdy, resp1_rdy,
        output xcel_req_val, xcel_req_msg,
        input  xcel_req_rdy,
        input  xcel_resp_val, xcel_resp_msg,
        output xcel_resp_rdy
    );

    // Environment view (requesters and accelerator)
    modport master (
        output req0_val, req0_msg, req1_val, req1_msg,
        input  req0_rdy, req1_rdy,
        input  resp0_val, resp0_msg, resp1_val, resp1_msg,
        output resp0_rdy, resp1_rdy,
        input  xcel_req_val, xcel_req_msg,
        output xcel_req_rdy,
        output xcel_resp_val, xcel_resp_msg,
        input  xcel_resp_rdy
    );
endinterface

// File: rtl/xcel_req_arbiter.sv
// Round-robin arbiter sharing one accelerator between two requesters; an in-order
// ID FIFO steers each accelerator response back to the requester that issued it.
module xcel_req_arbiter #(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input logic               clk,
    input logic               reset,
    xcel_req_arbiter_if.slave bus
);

    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic                       prio_q,    prio_d;
    logic                       lock_q,    lock_d;
    logic                       lock_id_q, lock_id_d;
    logic [MAX_OUTSTANDING-1:0] fifo_q,    fifo_d;
    logic [CW-1:0]              count_q,   count_d;
    logic [PW-1:0]              head_q,    head_d;
    logic [PW-1:0]              tail_q,    tail_d;

    logic winner_s;
    logic win_val_s;
    logic full_s;
    logic nonempty_s;
    logic head_id_s;
    logic run_s;
    logic req_fire_s;
    logic resp_fire_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] n;
        if (p == PW'(MAX_OUTSTANDING - 1)) begin
            n = {PW{1'b0}};
        end else begin
            n = p + PW'(1);
        end
        return n;
    endfunction

    // Winner selection: a pending offer keeps its grant, otherwise prio breaks ties
    always_comb begin
        winner_s = 1'b0;
        if (lock_q) begin
            winner_s = lock_id_q;
        end else if (bus.req0_val && bus.req1_val) begin
            winner_s = prio_q;
        end else if (bus.req1_val) begin
            winner_s = 1'b1;
        end else begin
            winner_s = 1'b0;
        end
    end

    assign run_s      = reset;
    assign win_val_s  = winner_s ? bus.req1_val : bus.req0_val;
    assign full_s     = (count_q == CW'(MAX_OUTSTANDING));
    assign nonempty_s = (count_q != {CW{1'b0}});
    assign head_id_s  = fifo_q[head_q];

    // While reset is low every handshake output is held low
    assign bus.xcel_req_val  = run_s && !full_s && win_val_s;
    assign bus.xcel_req_msg  = winner_s ? bus.req1_msg : bus.req0_msg;
    assign bus.req0_rdy      = run_s && !full_s && bus.xcel_req_rdy && !winner_s && bus.req0_val;
    assign bus.req1_rdy      = run_s && !full_s && bus.xcel_req_rdy &&  winner_s && bus.req1_val;

    assign bus.resp0_val     = run_s && bus.xcel_resp_val && nonempty_s && !head_id_s;
    assign bus.resp1_val     = run_s && bus.xcel_resp_val && nonempty_s &&  head_id_s;
    assign bus.resp0_msg     = bus.xcel_resp_msg;
    assign bus.resp1_msg     = bus.xcel_resp_msg;
    assign bus.xcel_resp_rdy = run_s && nonempty_s && (head_id_s ? bus.resp1_rdy : bus.resp0_rdy);

    assign req_fire_s  = bus.xcel_req_val && bus.xcel_req_rdy;
    assign resp_fire_s = bus.xcel_resp_val && bus.xcel_resp_rdy;

    // Next-state: grant lock, round-robin priority and ID FIFO push/pop
    always_comb begin
        prio_d    = prio_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        fifo_d    = fifo_q;
        count_d   = count_q;
        head_d    = head_q;
        tail_d    = tail_q;

        if (req_fire_s) begin
            lock_d         = 1'b0;
            prio_d         = !winner_s;
            fifo_d[tail_q] = winner_s;
            tail_d         = ptr_inc(tail_q);
        end else if (bus.xcel_req_val && !bus.xcel_req_rdy) begin
            lock_d    = 1'b1;
            lock_id_d = winner_s;
        end else begin
            lock_d    = lock_q;
        end

        if (resp_fire_s) begin
            head_d = ptr_inc(head_q);
        end else begin
            head_d = head_q;
        end

        case ({req_fire_s, resp_fire_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio_q    <= 1'b0;
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
            fifo_q    <= {MAX_OUTSTANDING{1'b0}};
            count_q   <= {CW{1'b0}};
            head_q    <= {PW{1'b0}};
            tail_q    <= {PW{1'b0}};
        end else begin
            prio_q    <= prio_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            fifo_q    <= fifo_d;
            count_q   <= count_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
        end
    end

endmodule

// File: tb/tb_xcel_req_arbiter.sv
// Scenario bench for xcel_req_arbiter: expected grants/routes are queued as
// stimulus is applied and compared mid-cycle when the DUT handshakes.
module tb_xcel_req_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    xcel_req_arbiter_if bus_if ();

    xcel_req_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks   = 0;
    int failures = 0;
    int gnt_q[$];
    int route_q[$];
    int xval_q[$];

    localparam logic [37:0] M_WR = {1'b1, 5'h01, 32'h0000_0005};
    localparam logic [37:0] M0   = {1'b0, 5'h02, 32'h0000_0000};
    localparam logic [37:0] M1   = {1'b0, 5'h03, 32'h0000_0000};
    localparam logic [32:0] R_WR = {1'b1, 32'h0000_0000};
    localparam logic [32:0] R0   = {1'b0, 32'h0000_000A};
    localparam logic [32:0] R1   = {1'b0, 32'h0000_000B};

    task automatic idle_inputs();
        bus_if.req0_val      = 1'b0;
        bus_if.req0_msg      = M0;
        bus_if.req1_val      = 1'b0;
        bus_if.req1_msg      = M1;
        bus_if.resp0_rdy     = 1'b0;
        bus_if.resp1_rdy     = 1'b0;
        bus_if.xcel_req_rdy  = 1'b0;
        bus_if.xcel_resp_val = 1'b0;
        bus_if.xcel_resp_msg = 33'h0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic apply_reset();
        next_cycle();
        idle_inputs();
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        gnt_q.delete();
        route_q.delete();
        xval_q.delete();
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        next_cycle();
        reset = 1'b0;
        bus_if.req0_val = 1'b1; bus_if.req1_val = 1'b1;
        bus_if.resp0_rdy = 1'b1; bus_if.resp1_rdy = 1'b1;
        bus_if.xcel_req_rdy = 1'b1; bus_if.xcel_resp_val = 1'b1;
        mid();
        outs = {bus_if.req0_rdy, bus_if.req1_rdy, bus_if.resp0_val, bus_if.resp1_val,
                bus_if.xcel_req_val, bus_if.xcel_resp_rdy};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected %b", outs, 6'b0);
        end
        next_cycle();
        idle_inputs();
        reset = 1'b1;
    endtask

    task automatic test_single();
        int exp;
        apply_reset();
        gnt_q.push_back(0);
        bus_if.req0_val = 1'b1; bus_if.req0_msg = M_WR; bus_if.xcel_req_rdy = 1'b1;
        mid();
        exp = gnt_q.pop_front();
        checks++;
        if ({bus_if.xcel_req_val, bus_if.req0_rdy, bus_if.req1_rdy} !== {1'b1, exp == 0, exp == 1}) begin
            failures++;
            $display("FAIL single_grant: got val/rdy0/rdy1=%b%b%b expected 1%b%b",
                     bus_if.xcel_req_val, bus_if.req0_rdy, bus_if.req1_rdy, exp == 0, exp == 1);
        end
        checks++;
        if (bus_if.xcel_req_msg !== M_WR) begin
            failures++;
            $display("FAIL single_msg: got %h expected %h", bus_if.xcel_req_msg, M_WR);
        end
        route_q.push_back(exp);
        next_cycle();
        bus_if.req0_val = 1'b0;
        bus_if.xcel_resp_val = 1'b1; bus_if.xcel_resp_msg = R_WR; bus_if.resp0_rdy = 1'b1;
        mid();
        exp = route_q.pop_front();
        checks++;
        if ({bus_if.resp1_val, bus_if.resp0_val, bus_if.xcel_resp_rdy} !== {exp == 1, exp == 0, 1'b1}) begin
            failures++;
            $display("FAIL single_resp_route: got v1/v0/rdy=%b%b%b expected %b%b1",
                     bus_if.resp1_val, bus_if.resp0_val, bus_if.xcel_resp_rdy, exp == 1, exp == 0);
        end
        checks++;
        if (bus_if.resp0_msg !== R_WR) begin
            failures++;
            $display("FAIL single_resp_msg: got %h expected %h", bus_if.resp0_msg, R_WR);
        end
        next_cycle();
        mid();
        checks++;
        if ({bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val} !== 3'b000) begin
            failures++;
            $display("FAIL single_drained: got rdy/v0/v1=%b%b%b expected 000",
                     bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val);
        end
        idle_inputs();
    endtask

    task automatic test_round_robin();
        int eg, er;
        logic [32:0] exp_msg;
        apply_reset();
        gnt_q.push_back(0); gnt_q.push_back(1); gnt_q.push_back(0); gnt_q.push_back(1);
        bus_if.req0_msg = M0; bus_if.req1_msg = M1;
        bus_if.xcel_req_rdy = 1'b1; bus_if.resp0_rdy = 1'b1; bus_if.resp1_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_if.req0_val = (i < 4);
            bus_if.req1_val = (i < 4);
            bus_if.xcel_resp_val = (route_q.size() > 0);
            bus_if.xcel_resp_msg = (route_q.size() > 0 && route_q[0] == 1) ? R1 : R0;
            mid();
            if (route_q.size() > 0) begin
                er = route_q.pop_front();
                exp_msg = (er == 1) ? R1 : R0;
                checks++;
                if ({bus_if.resp1_val, bus_if.resp0_val, bus_if.xcel_resp_rdy} !== {er == 1, er == 0, 1'b1}) begin
                    failures++;
                    $display("FAIL rr_resp_route[%0d]: got v1/v0/rdy=%b%b%b expected %b%b1", i,
                             bus_if.resp1_val, bus_if.resp0_val, bus_if.xcel_resp_rdy, er == 1, er == 0);
                end
                checks++;
                if (((er == 1) ? bus_if.resp1_msg : bus_if.resp0_msg) !== exp_msg) begin
                    failures++;
                    $display("FAIL rr_resp_msg[%0d]: got %h expected %h", i,
                             (er == 1) ? bus_if.resp1_msg : bus_if.resp0_msg, exp_msg);
                end
            end
            if (i < 4) begin
                eg = gnt_q.pop_front();
                checks++;
                if ({bus_if.req0_rdy, bus_if.req1_rdy} !== {eg == 0, eg == 1}) begin
                    failures++;
                    $display("FAIL rr_grant[%0d]: got rdy0/rdy1=%b%b expected %b%b", i,
                             bus_if.req0_rdy, bus_if.req1_rdy, eg == 0, eg == 1);
                end
                checks++;
                if (bus_if.xcel_req_msg !== ((eg == 1) ? M1 : M0)) begin
                    failures++;
                    $display("FAIL rr_msg[%0d]: got %h expected %h", i,
                             bus_if.xcel_req_msg, (eg == 1) ? M1 : M0);
                end
                route_q.push_back(eg);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_lock();
        logic r0v[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic rdy[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        int ids[5]   = '{1, 1, 1, 1, 0};
        int eg;
        apply_reset();
        for (int i = 0; i < 5; i++) gnt_q.push_back(ids[i]);
        for (int i = 0; i < 5; i++) begin
            bus_if.req1_val = 1'b1;
            bus_if.req0_val = r0v[i];
            bus_if.xcel_req_rdy = rdy[i];
            mid();
            eg = gnt_q.pop_front();
            checks++;
            if (bus_if.xcel_req_val !== 1'b1 || bus_if.xcel_req_msg !== ((eg == 1) ? M1 : M0)) begin
                failures++;
                $display("FAIL lock_msg[%0d]: got val=%b msg=%h expected val=1 msg=%h", i,
                         bus_if.xcel_req_val, bus_if.xcel_req_msg, (eg == 1) ? M1 : M0);
            end
            checks++;
            if ({bus_if.req0_rdy, bus_if.req1_rdy} !== {rdy[i] && eg == 0, rdy[i] && eg == 1}) begin
                failures++;
                $display("FAIL lock_rdy[%0d]: got rdy0/rdy1=%b%b expected %b%b", i,
                         bus_if.req0_rdy, bus_if.req1_rdy, rdy[i] && eg == 0, rdy[i] && eg == 1);
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_full();
        logic rv[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int xv[6]   = '{1, 1, 0, 0, 1, 0};
        int ev;
        apply_reset();
        for (int i = 0; i < 6; i++) xval_q.push_back(xv[i]);
        bus_if.req0_val = 1'b1; bus_if.req0_msg = M0;
        bus_if.xcel_req_rdy = 1'b1; bus_if.resp0_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus_if.xcel_resp_val = rv[i];
            bus_if.xcel_resp_msg = R0;
            mid();
            ev = xval_q.pop_front();
            checks++;
            if ({bus_if.xcel_req_val, bus_if.req0_rdy} !== {ev == 1, ev == 1}) begin
                failures++;
                $display("FAIL full_req[%0d]: got val/rdy0=%b%b expected %b%b", i,
                         bus_if.xcel_req_val, bus_if.req0_rdy, ev == 1, ev == 1);
            end
            if (rv[i]) begin
                checks++;
                if ({bus_if.resp0_val, bus_if.xcel_resp_rdy} !== 2'b11) begin
                    failures++;
                    $display("FAIL full_resp[%0d]: got v0/rdy=%b%b expected 11", i,
                             bus_if.resp0_val, bus_if.xcel_resp_rdy);
                end
            end
            next_cycle();
        end
        idle_inputs();
    endtask

    task automatic test_empty_stall();
        apply_reset();
        bus_if.xcel_resp_val = 1'b1; bus_if.xcel_resp_msg = R0;
        mid();
        checks++;
        if ({bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val} !== 3'b000) begin
            failures++;
            $display("FAIL empty_resp: got rdy/v0/v1=%b%b%b expected 000",
                     bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val);
        end
        next_cycle();
        bus_if.req0_val = 1'b1; bus_if.xcel_req_rdy = 1'b1;
        next_cycle();
        bus_if.req0_val = 1'b0; bus_if.resp0_rdy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mid();
            checks++;
            if ({bus_if.resp0_val, bus_if.xcel_resp_rdy} !== 2'b10) begin
                failures++;
                $display("FAIL stall_head[%0d]: got v0/rdy=%b%b expected 10", i,
                         bus_if.resp0_val, bus_if.xcel_resp_rdy);
            end
            next_cycle();
        end
        bus_if.resp0_rdy = 1'b1;
        mid();
        checks++;
        if ({bus_if.resp0_val, bus_if.xcel_resp_rdy} !== 2'b11) begin
            failures++;
            $display("FAIL stall_release: got v0/rdy=%b%b expected 11",
                     bus_if.resp0_val, bus_if.xcel_resp_rdy);
        end
        next_cycle();
        mid();
        checks++;
        if ({bus_if.resp0_val, bus_if.xcel_resp_rdy} !== 2'b00) begin
            failures++;
            $display("FAIL stall_popped: got v0/rdy=%b%b expected 00",
                     bus_if.resp0_val, bus_if.xcel_resp_rdy);
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        logic [5:0] outs;
        apply_reset();
        bus_if.req0_val = 1'b1; bus_if.req1_val = 1'b1; bus_if.xcel_req_rdy = 1'b1;
        mid();
        checks++;
        if ({bus_if.req0_rdy, bus_if.req1_rdy} !== 2'b10) begin
            failures++;
            $display("FAIL rmid_first: got rdy0/rdy1=%b%b expected 10", bus_if.req0_rdy, bus_if.req1_rdy);
        end
        next_cycle();
        mid();
        checks++;
        if ({bus_if.req0_rdy, bus_if.req1_rdy} !== 2'b01) begin
            failures++;
            $display("FAIL rmid_second: got rdy0/rdy1=%b%b expected 01", bus_if.req0_rdy, bus_if.req1_rdy);
        end
        next_cycle();
        reset = 1'b0;
        bus_if.resp0_rdy = 1'b1; bus_if.resp1_rdy = 1'b1; bus_if.xcel_resp_val = 1'b1;
        mid();
        outs = {bus_if.req0_rdy, bus_if.req1_rdy, bus_if.resp0_val, bus_if.resp1_val,
                bus_if.xcel_req_val, bus_if.xcel_resp_rdy};
        checks++;
        if (outs !== 6'b0) begin
            failures++;
            $display("FAIL rmid_outputs: got %b expected %b", outs, 6'b0);
        end
        next_cycle();
        reset = 1'b1;
        mid();
        checks++;
        if ({bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val} !== 3'b000) begin
            failures++;
            $display("FAIL rmid_discard: got rdy/v0/v1=%b%b%b expected 000",
                     bus_if.xcel_resp_rdy, bus_if.resp0_val, bus_if.resp1_val);
        end
        checks++;
        if ({bus_if.req0_rdy, bus_if.req1_rdy} !== 2'b10 || bus_if.xcel_req_msg !== M0) begin
            failures++;
            $display("FAIL rmid_regrant: got rdy0/rdy1=%b%b msg=%h expected 10 msg=%h",
                     bus_if.req0_rdy, bus_if.req1_rdy, bus_if.xcel_req_msg, M0);
        end
        next_cycle();
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_full();
        test_empty_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xcel_req_arbiter.md
Name: xcel_req_arbiter

Overview:
Two-requester to one-accelerator arbiter for the accelerator register interface, which uses the xcel_req_t and xcel_resp_t val/rdy messages. It shares a single accelerator between two requesters, for example two processor ports or a processor plus a debug/config master. Requests are granted round-robin. Responses are routed back to the correct requester using an in-order ID FIFO, so the accelerator needs no requester ID field. The block sits between the requesters' xcel ports and the accelerator's xcel port.

Parameters:
MAX_OUTSTANDING, 2, depth of the ID FIFO: the maximum number of granted requests whose responses have not yet returned (must be >= 1).

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous active-low reset; state is reset on the rising edge of clk while reset==0
req0_val  in  1  requester 0 request valid
req0_rdy  out  1  requester 0 request ready
req0_msg  in  38  requester 0 request (xcel_req_t: type_, addr[4:0], data[31:0])
req1_val  in  1  requester 1 request valid
req1_rdy  out  1  requester 1 request ready
req1_msg  in  38  requester 1 request (xcel_req_t)
resp0_val  out  1  response valid to requester 0
resp0_rdy  in  1  requester 0 response ready
resp0_msg  out  33  response to requester 0 (xcel_resp_t: type_, data[31:0])
resp1_val  out  1  response valid to requester 1
resp1_rdy  in  1  requester 1 response ready
resp1_msg  out  33  response to requester 1 (xcel_resp_t)
xcel_req_val  out  1  request valid to accelerator
xcel_req_rdy  in  1  accelerator request ready
xcel_req_msg  out  38  forwarded request
xcel_resp_val  in  1  accelerator response valid
xcel_resp_rdy  out  1  response ready to accelerator
xcel_resp_msg  in  33  accelerator response

Behaviour:
- Transfer ("fire") occurs on a cycle where val && rdy for that channel. All data paths are combinational, so grant-to-accelerator and response-to-requester each add zero cycles of latency.
- State:
  - prio (1b): the requester favoured next.
  - lock (1b) and lock_id (1b): grant hold.
  - ID FIFO: MAX_OUTSTANDING entries of 1b; count width is clog2(MAX_OUTSTANDING+1); head and tail pointers wrap modulo MAX_OUTSTANDING.
- Reset (reset==0 at a clock edge): prio=0, lock=0, count=0, pointers=0. While reset==0, every val/rdy output is forced to 0 (req0_rdy, req1_rdy, resp0_val, resp1_val, xcel_req_val, xcel_resp_rdy). Reset mid-transaction discards all outstanding IDs; any response arriving afterwards meets xcel_resp_rdy=0 and stalls.
- Winner selection:
  - If lock=1, winner = lock_id.
  - Otherwise, if both requesters are valid, winner = prio.
  - Otherwise, winner = whichever requester is valid.
- full = (count==MAX_OUTSTANDING).
- xcel_req_val = !full && (reqW_val); xcel_req_msg = reqW_msg, where W is the winner.
- reqN_rdy = !full && xcel_req_rdy && (W==N) && reqN_val. The non-winner's rdy is 0.
- Grant stability: if xcel_req_val=1 and xcel_req_rdy=0, set lock=1 and lock_id=W. Clear lock on the fire. The winner must not change while an offered request is pending.
- On request fire: push W into the ID FIFO and set prio = !W.
- Full: no request is offered (xcel_req_val=0), even if a response pops in the same cycle. There is no push/pop bypass.
- Response routing, with H = FIFO head:
  - respH_val = xcel_resp_val && (count>0).
  - Both respN_msg = xcel_resp_msg.
  - The non-head resp val is 0.
  - xcel_resp_rdy = (count>0) && respH_rdy.
- Empty FIFO: xcel_resp_rdy=0 and no resp val is asserted.
- On response fire: pop the head.
- Simultaneous request fire and response fire: one push and one pop in the same cycle; count is unchanged and both pointers advance.
- The accelerator returns responses in request order. The arbiter does not inspect type_.

Test Plan:
- Only req0 valid with wr addr=0x01 data=0x00000005, accelerator always ready → xcel_req_msg equals the request in the same cycle and req0_rdy=1. Then accelerator resp wr → resp0_val=1, resp1_val=0, and count returns to 0.
- Both requesters valid every cycle with accelerator always ready (req0 rd 0x02, req1 rd 0x03) → grants alternate 0,1,0,1 starting with 0 after reset. Read responses 0x0000000A and 0x0000000B are delivered to resp0 and resp1 respectively, in order.
- req1 offered alone with xcel_req_rdy=0 for 3 cycles, req0 raised in cycle 2 → xcel_req_msg stays req1 throughout. req1 fires in cycle 4, then req0 is granted next.
- MAX_OUTSTANDING=2 with accelerator responses withheld: 2 requests fire, then a third is held with xcel_req_val=0. Returning one response allows the third to fire on the following cycle, not the same cycle.
- Response arriving with the FIFO empty → xcel_resp_rdy=0 and no resp val. resp0_rdy=0 while resp0 is the head → xcel_resp_rdy=0 and the head is not popped.
- Assert reset=0 for 1 cycle with 2 outstanding requests → count=0, prio=0, all val/rdy outputs are 0 during reset, and the first post-reset contested grant goes to req0.
